// File: rtl/conv_stream_pkg.sv
// Shared types for the convolution result stream path: reader FSM states and the buffered beat.
// The beat carries a start-of-frame flag only when READER_SOF_EN is defined.
package conv_stream_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 12;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } rd_state_t;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic                  last;
      logic                  eof;
`ifdef READER_SOF_EN
      logic                  sof;
`endif
   } beat_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry beat FIFO that soaks up the one-cycle memory read latency so the
// reader can keep issuing reads while the downstream stalls.
module stream_skid_fifo
   import conv_stream_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  beat_t      push_beat,
   input  logic       pop,
   output beat_t      head,
   output logic [1:0] occupancy
);

   beat_t      mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_beat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head      = mem[rd_ptr];
   assign occupancy = count;

endmodule

// File: rtl/result_stream_reader.sv
// Walks the result memory in raster order and streams it out as valid/ready beats.
// Define READER_SOF_EN to add the m_sof output marking the first beat of each frame.
module result_stream_reader
   import conv_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  width,
   input  logic [CNT_W-1:0]  height,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              m_eof,
`ifdef READER_SOF_EN
   output logic              m_sof,
`endif
   output logic              busy,
   output logic              done
);

   localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   rd_state_t         state, state_nxt;
   logic [CNT_W-1:0]  w_q, h_q, col, row;
   logic [ADDR_W-1:0] addr;
   logic              done_nxt;
   logic              start_ok, issue, pop;
   logic              at_row_end, at_frame_end;
   logic [1:0]        occupancy;
   beat_t             head, push_beat;

   logic              vld_p1, last_p1, eof_p1;
`ifdef READER_SOF_EN
   logic              sof_p1;
`endif

   assign start_ok     = (state == IDLE) && start && (width != '0) && (height != '0);
   assign at_row_end   = (col == w_q - CNT_ONE);
   assign at_frame_end = at_row_end && (row == h_q - CNT_ONE);
   assign pop          = m_valid & m_ready;
   // A read is only issued if its data is guaranteed a free FIFO slot on arrival.
   assign issue        = (state == RUN) &&
                         (({1'b0, occupancy} + {2'b0, vld_p1}) < (3'd2 + {2'b0, pop}));

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if ((width != '0) && (height != '0)) state_nxt = RUN;
               else                                 done_nxt  = 1'b1;
            end
         end
         RUN: begin
            if (issue && at_frame_end) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!vld_p1 && (occupancy == {1'b0, pop})) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p1: read in flight; flags ride alongside until the data returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         done    <= 1'b0;
         w_q     <= '0;
         h_q     <= '0;
         col     <= '0;
         row     <= '0;
         addr    <= '0;
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         eof_p1  <= 1'b0;
`ifdef READER_SOF_EN
         sof_p1  <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         done    <= done_nxt;
         vld_p1  <= issue;
         last_p1 <= at_row_end;
         eof_p1  <= at_frame_end;
`ifdef READER_SOF_EN
         sof_p1  <= (row == '0) && (col == '0);
`endif
         if (start_ok) begin
            w_q  <= width;
            h_q  <= height;
            col  <= '0;
            row  <= '0;
            addr <= '0;
         end else if (issue) begin
            addr <= addr + ADDR_ONE;
            if (at_row_end) begin
               col <= '0;
               if (row != h_q - CNT_ONE) row <= row + CNT_ONE;
            end else begin
               col <= col + CNT_ONE;
            end
         end
      end
   end

   // Stage p2: returned data joins its flags and enters the output buffer.
   always_comb begin
      push_beat      = '0;
      push_beat.data = mem_rdata;
      push_beat.last = last_p1;
      push_beat.eof  = eof_p1;
`ifdef READER_SOF_EN
      push_beat.sof  = sof_p1;
`endif
   end

   stream_skid_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (vld_p1),
      .push_beat (push_beat),
      .pop       (pop),
      .head      (head),
      .occupancy (occupancy)
   );

   assign mem_rd_en = issue;
   assign mem_addr  = addr;
   assign m_valid   = (occupancy != 2'd0);
   assign m_data    = head.data;
   assign m_last    = head.last;
   assign m_eof     = head.eof;
`ifdef READER_SOF_EN
   assign m_sof     = head.sof;
`endif
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_result_stream_reader.sv
// Directed bench for result_stream_reader: a frame-level model predicts every beat,
// and a per-cycle monitor compares the DUT against it.
module tb_result_stream_reader;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 12;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [CNT_W-1:0]  width = '0;
   logic [CNT_W-1:0]  height = '0;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              m_valid;
   logic              m_ready = 1'b1;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic              m_eof;
`ifdef READER_SOF_EN
   logic              m_sof;
`endif
   logic              busy;
   logic              done;

   result_stream_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .width     (width),
      .height    (height),
      .mem_rd_en (mem_rd_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .m_eof     (m_eof),
`ifdef READER_SOF_EN
      .m_sof     (m_sof),
`endif
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        last;
      logic        eof;
      logic        sof;
   } exp_t;

   exp_t exp_q[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rdy_mode = 0;
   bit mon_en = 0;
   int rd_cnt = 0, beat_cnt = 0, last_cnt = 0, total_exp = 0;
   int start_cyc = 0, first_rd_cyc = -1, first_valid_cyc = -1;
   int exp_done_cyc = -1, eof_cyc = -1, done_cyc = -1;
   bit busy_exp = 0;
   logic [15:0] last_data = '0;
   bit stall_prev = 0;
   logic [15:0] hold_data;
   logic hold_last, hold_eof;

   function automatic logic [15:0] memf(input int a);
      return 16'hA000 ^ a[15:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Result memory: one-cycle synchronous read.
   always @(posedge clk) if (mem_rd_en) mem_rdata <= memf(int'(mem_addr));

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 1) m_ready = ~m_ready;
         else               m_ready = 1'b1;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("done", done, cyc == exp_done_cyc);
         chk("busy", busy, busy_exp);
         if (stall_prev) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, hold_data);
            chk("hold_last", m_last, hold_last);
            chk("hold_eof", m_eof, hold_eof);
         end
         if (mem_rd_en) begin
            if (rd_cnt >= total_exp) chk("extra_read", rd_cnt, total_exp);
            else chk("rd_addr", mem_addr, rd_cnt % 4096);
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            rd_cnt++;
         end
         if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", beat_cnt, total_exp);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", m_data, e.data);
               chk("beat_last", m_last, e.last);
               chk("beat_eof", m_eof, e.eof);
`ifdef READER_SOF_EN
               chk("beat_sof", m_sof, e.sof);
`endif
               if (e.eof) begin
                  exp_done_cyc = cyc + 1;
                  busy_exp = 0;
               end
            end
            beat_cnt++;
            if (m_last) last_cnt++;
            if (m_eof) eof_cyc = cyc;
            last_data = m_data;
         end
         chk("outstanding", (rd_cnt - beat_cnt) <= 2, 1);
         stall_prev = m_valid && !m_ready;
         hold_data = m_data;
         hold_last = m_last;
         hold_eof = m_eof;
      end
   end

   task automatic start_frame(input int w, input int h);
      exp_t e;
      width = w[CNT_W-1:0];
      height = h[CNT_W-1:0];
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      start_cyc = cyc;
      rd_cnt = 0;
      beat_cnt = 0;
      last_cnt = 0;
      first_rd_cyc = -1;
      first_valid_cyc = -1;
      total_exp = w * h;
      if (w * h == 0) begin
         exp_done_cyc = cyc;
      end else begin
         busy_exp = 1;
         for (int i = 0; i < w * h; i++) begin
            e.data = memf(i);
            e.last = ((i % w) == w - 1);
            e.eof = (i == w * h - 1);
            e.sof = (i == 0);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic wait_done(input int bound);
      bit got = 0;
      for (int i = 0; i < bound && !got; i++) begin
         @(negedge clk);
         #1;
         if (done) begin
            got = 1;
            done_cyc = cyc;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         done_cyc = -1;
         $display("FAIL done_timeout: no done within %0d cycles", bound);
      end
   endtask

   task automatic wait_beats(input int n);
      bit got = 0;
      for (int i = 0; i < 500 && !got; i++) begin
         @(negedge clk);
         #1;
         if (beat_cnt >= n) got = 1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: got %0d beats, needed %0d", beat_cnt, n);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_rd_en"}, mem_rd_en, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_valid"}, m_valid, 0);
      chk({tag, "_data"}, m_data, 0);
      chk({tag, "_last"}, m_last, 0);
      chk({tag, "_eof"}, m_eof, 0);
`ifdef READER_SOF_EN
      chk({tag, "_sof"}, m_sof, 0);
`endif
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      mon_en = 1;

      // 4x3 at full throughput
      start_frame(4, 3);
      wait_done(100);
      chk("A_first_rd", first_rd_cyc - start_cyc, 0);
      chk("A_first_valid", first_valid_cyc - start_cyc, 2);
      chk("A_beats", beat_cnt, 12);
      chk("A_reads", rd_cnt, 12);
      chk("A_lasts", last_cnt, 3);
      chk("A_last_data", last_data, 16'hA00B);
      chk("A_done_lat", done_cyc - eof_cyc, 1);
      chk("A_bursts", (eof_cyc - first_valid_cyc), 11);

      // Same frame under alternating back-pressure
      rdy_mode = 1;
      start_frame(4, 3);
      wait_done(200);
      rdy_mode = 0;
      chk("B_beats", beat_cnt, 12);
      chk("B_last_data", last_data, 16'hA00B);
      chk("B_done_lat", done_cyc - eof_cyc, 1);

      // Zero-sized frame
      start_frame(0, 5);
      wait_done(20);
      repeat (4) @(negedge clk);
      #1;
      chk("Z_done_lat", done_cyc - start_cyc, 0);
      chk("Z_reads", rd_cnt, 0);
      chk("Z_beats", beat_cnt, 0);

      // Single-pixel frame
      start_frame(1, 1);
      wait_done(20);
      chk("S_beats", beat_cnt, 1);
      chk("S_data", last_data, 16'hA000);
      chk("S_lasts", last_cnt, 1);

      // Restart ignored mid-frame, then accepted in the done cycle
      start_frame(4, 3);
      wait_beats(5);
      width = 7;
      height = 7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(200);
      chk("I_beats", beat_cnt, 12);
      chk("I_last_data", last_data, 16'hA00B);
      start_frame(2, 3);
      wait_done(100);
      chk("D_first_valid", first_valid_cyc - start_cyc, 2);
      chk("D_beats", beat_cnt, 6);
      chk("D_last_data", last_data, 16'hA005);
      chk("D_lasts", last_cnt, 3);

      // Asynchronous reset mid-frame with a read in flight
      start_frame(4, 3);
      wait_beats(6);
      #1;
      rst = 1'b1;
      mon_en = 0;
      #1;
      check_outputs_zero("midrst");
      @(negedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      busy_exp = 0;
      exp_done_cyc = -1;
      stall_prev = 0;
      total_exp = 0;
      rd_cnt = 0;
      beat_cnt = 0;
      mon_en = 1;
      start_frame(2, 2);
      wait_done(100);
      chk("R_beats", beat_cnt, 4);
      chk("R_first_addr_lat", first_rd_cyc - start_cyc, 0);
      chk("R_last_data", last_data, 16'hA003);
      chk("R_queue_empty", exp_q.size(), 0);

      repeat (3) @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
